prefix_addsub_pipe: RTL and testbench

PREFIX_ADDSUB_PIPE -- requirements
Module: prefix_addsub_pipe

---
 rtl/prefix_addsub_pipe.sv | 133 +++++++++++++
 tb/tb_prefix_addsub_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: s = a + (op ? ~b : b) + c, with cout, ovf, zero.
// Latency: STAGES cycles from acceptance to out_valid; one result per cycle when unstalled.
// Backpressure: global stall, in_ready = out_ready || !out_valid; all stages hold while stalled.
// Optional macro PREFIX_ADDSUB_FLAGS_EN enables the ovf/zero flags (tied to 0 otherwise).
module prefix_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int SDIV   = (STAGES > 1) ? STAGES - 1 : 1;

  // Level 0 (operand pre-processing) is always registered; the remaining
  // STAGES-1 registers sit after prefix levels ceil(k*LEVELS/(STAGES-1)),
  // which always puts the last one after the final prefix level.
  function automatic logic reg_after(input int lv);
    logic r;
    r = (lv == 0);
    for (int k = 1; k < STAGES; k++) begin
      if ((k * LEVELS + SDIV - 1) / SDIV == lv) r = 1'b1;
    end
    return r;
  endfunction

  // The whole pipe advances together: a beat moves only when the output slot frees up.
  assign in_ready = out_ready || !out_valid;

  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    // *_d: combinational result of this level, *_q: value handed to the next level.
    // g/p are group generate/propagate, po is the original per-bit propagate,
    // cc is the carry-in, v is the beat valid bit.
    logic [WIDTH-1:0] g_d, p_d, po_d;
    logic [WIDTH-1:0] g_q, p_q, po_q;
    logic             c_d, v_d, c_q, v_q;

    if (l == 0) begin : g_pre
      logic [WIDTH-1:0] bx;
      assign bx   = op ? ~b : b;
      assign p_d  = a ^ bx;
      assign po_d = a ^ bx;
      // Fold the carry-in into bit 0 so every prefix group from bit 0 carries it.
      assign g_d  = (a & bx) | {{(WIDTH-1){1'b0}}, (a[0] ^ bx[0]) & c};
      assign c_d  = c;
      assign v_d  = in_valid;
    end else begin : g_comb
      localparam int D = 1 << (l - 1);
      // One Kogge-Stone combine level: merge each group with the one D bits below.
      always_comb begin
        g_d = lvl[l-1].g_q;
        p_d = lvl[l-1].p_q;
        for (int i = D; i < WIDTH; i++) begin
          g_d[i] = lvl[l-1].g_q[i] | (lvl[l-1].p_q[i] & lvl[l-1].g_q[i-D]);
          p_d[i] = lvl[l-1].p_q[i] & lvl[l-1].p_q[i-D];
        end
      end
      assign po_d = lvl[l-1].po_q;
      assign c_d  = lvl[l-1].c_q;
      assign v_d  = lvl[l-1].v_q;
    end

    if (reg_after(l)) begin : g_reg
      // Stage register: moves with the pipe; data loads only for valid beats so bubbles keep the last result.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q  <= 1'b0;
          g_q  <= '0;
          p_q  <= '0;
          po_q <= '0;
          c_q  <= 1'b0;
        end else if (in_ready) begin
          v_q <= v_d;
          if (v_d) begin
            g_q  <= g_d;
            p_q  <= p_d;
            po_q <= po_d;
            c_q  <= c_d;
          end
        end
      end
    end else begin : g_wire
      assign v_q  = v_d;
      assign g_q  = g_d;
      assign p_q  = p_d;
      assign po_q = po_d;
      assign c_q  = c_d;
    end
  end

  // Carry into bit i is the group generate of bits [i-1:0] (plus carry-in).
  logic [WIDTH-1:0] carry_in;
  logic             unused_p;

  assign carry_in  = {lvl[LEVELS].g_q[WIDTH-2:0], lvl[LEVELS].c_q};
  assign s         = carry_in ^ lvl[LEVELS].po_q;
  assign cout      = lvl[LEVELS].g_q[WIDTH-1];
  assign out_valid = lvl[LEVELS].v_q;
  assign unused_p  = ^lvl[LEVELS].p_q;

`ifdef PREFIX_ADDSUB_FLAGS_EN
  logic res_seen;

  // Remembers that a real result has been presented, so zero stays low out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_seen <= 1'b0;
    end else if (out_valid) begin
      res_seen <= 1'b1;
    end
  end

  assign ovf  = carry_in[WIDTH-1] ^ cout;
  assign zero = (out_valid | res_seen) & ~|s;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Randomized self-checking bench for prefix_addsub_pipe (WIDTH=32, STAGES=2).
// Reference model uses plain 33-bit arithmetic and a queue of expected results.
// Flag expectations follow whether PREFIX_ADDSUB_FLAGS_EN is defined for the build.
module tb_prefix_addsub_pipe;

`ifdef PREFIX_ADDSUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        c = 1'b0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] s;
  logic        cout, ovf, zero;

  int checks = 0;
  int errors = 0;

  logic [34:0] expq[$];
  logic [34:0] last = '0;
  logic [34:0] exp_r;
  logic [34:0] got;

  assign got = {s, cout, ovf, zero};

  always #5 clk = ~clk;

  prefix_addsub_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // Reference: {s, cout, ovf, zero} from ordinary wide addition.
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic mop);
    logic [31:0] bx;
    logic [32:0] sum;
    logic        v;
    bx  = mop ? ~mb : mb;
    sum = {1'b0, ma} + {1'b0, bx} + {32'd0, mc};
    v   = (ma[31] == bx[31]) && (sum[31] != ma[31]);
    return {sum[31:0], sum[32], v & FLAGS, (sum[31:0] == 32'd0) & FLAGS};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic iop, input logic ordy);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; c = ic; op = iop; out_ready = ordy;
    #1;
  endtask

  task automatic drive_rand(input logic iv, input logic ordy);
    logic [31:0] ra, rb;
    ra = $urandom;
    rb = $urandom;
    if ($urandom_range(0, 3) == 0) rb = ~ra;
    if ($urandom_range(0, 7) == 0) ra = 32'h7FFF_FFFF;
    drive(iv, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
  endtask

  task automatic track_in();
    if (in_valid && in_ready && rst_n) expq.push_back(model(a, b, c, op));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) drive_rand(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    checks++; if (s !== 32'd0) begin errors++; $display("FAIL rst_s got=%h required=0", s); end
    checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b required=000", {cout, ovf, zero}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
    repeat (4) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ignore_in got=%b required=0", out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[3], tb_[3];
    logic        tc[3], top_[3];
    logic [34:0] te[3];
    ta[0] = 32'hFFFF_FFFF; tb_[0] = 32'h1; tc[0] = 1'b0; top_[0] = 1'b0; te[0] = {32'h0, 1'b1, 1'b0, FLAGS};
    ta[1] = 32'h7FFF_FFFF; tb_[1] = 32'h1; tc[1] = 1'b0; top_[1] = 1'b0; te[1] = {32'h8000_0000, 1'b0, FLAGS, 1'b0};
    ta[2] = 32'h5;         tb_[2] = 32'h7; tc[2] = 1'b1; top_[2] = 1'b1; te[2] = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ta[i], tb_[i], tc[i], top_[i], 1'b1);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early got=%b required=0", i, out_valid); end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got=%b required=1", i, out_valid); end
      checks++; if (got !== te[i]) begin errors++; $display("FAIL dir%0d_result got=%h required=%h", i, got, te[i]); end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0 || got !== te[i]) begin errors++; $display("FAIL dir%0d_hold got=%b/%h required=0/%h", i, out_valid, got, te[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      drive_rand(i < 16, 1'b1);
      checks++; if (out_valid !== (i >= 2 && i < 18)) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%b required=%b", i, out_valid, (i >= 2 && i < 18)); end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL b2b_extra got=%h required=no beat", got); end
        else begin exp_r = expq.pop_front(); last = exp_r; if (got !== exp_r) begin errors++; $display("FAIL b2b_result got=%h required=%h", got, exp_r); end end
      end
      track_in();
    end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL b2b_lost got=%0d required=0", expq.size()); end
  endtask

  task automatic test_stall();
    int drained = 0;
    repeat (2) begin drive_rand(1'b1, 1'b0); track_in(); end
    repeat (5) begin
      drive_rand(1'b1, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
      checks++; if (out_valid !== 1'b1 || got !== expq[0]) begin errors++; $display("FAIL stall_hold got=%b/%h required=1/%h", out_valid, got, expq[0]); end
      track_in();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (out_valid && out_ready) begin
        checks++; drained++;
        if (expq.size() == 0) begin errors++; $display("FAIL stall_extra got=%h required=no beat", got); end
        else begin exp_r = expq.pop_front(); last = exp_r; if (got !== exp_r) begin errors++; $display("FAIL stall_result got=%h required=%h", got, exp_r); end end
      end
    end
    checks++; if (drained != 2 || expq.size() != 0) begin errors++; $display("FAIL stall_count got=%0d/%0d required=2/0", drained, expq.size()); end
  endtask

  task automatic test_mid_reset();
    drive_rand(1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || s !== 32'd0) begin errors++; $display("FAIL mrst_clear got=%b/%h required=0/0", out_valid, s); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_ghost cyc=%0d got=%b required=0", i, out_valid); end
    end
    expq.delete();
    last = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 310; i++) begin
      if (i < 300) drive_rand(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      else drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (!out_valid) begin
        checks++; if (got !== last) begin errors++; $display("FAIL rnd_hold got=%h required=%h", got, last); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL rnd_extra got=%h required=no beat", got); end
        else begin exp_r = expq.pop_front(); last = exp_r; if (got !== exp_r) begin errors++; $display("FAIL rnd_result got=%h required=%h", got, exp_r); end end
      end
      track_in();
    end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d required=0", expq.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
